// File: rtl/lfsr_stim_sequencer.sv
// Multi-channel LFSR stimulus sequencer for a pipelined cipher core.
// Issues a programmable number of vectors, tracks core latency and folds responses into a MISR.
module lfsr_stim_sequencer #(
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned NUM_CHANNELS = 2,
  parameter int unsigned PIPE_LATENCY = 21,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [COUNT_WIDTH-1:0]               num_tests,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]   seeds,
  input  logic                                 stall,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]   stim_data,
  output logic                                 stim_valid,
  input  logic [DATA_WIDTH-1:0]                resp_data,
  output logic                                 resp_capture,
  output logic                                 busy,
  output logic                                 done,
  output logic [COUNT_WIDTH-1:0]               tests_issued,
  output logic [DATA_WIDTH-1:0]                signature
);

  localparam int unsigned STIM_WIDTH = NUM_CHANNELS * DATA_WIDTH;

  // Tap positions (0-based) shared by the stimulus LFSRs and the MISR.
  localparam int unsigned TAP_A = DATA_WIDTH - 1;
  localparam int unsigned TAP_B = (DATA_WIDTH == 32) ? 21 : (DATA_WIDTH == 64) ? 62 : 125;
  localparam int unsigned TAP_C = (DATA_WIDTH == 32) ? 1  : (DATA_WIDTH == 64) ? 60 : 100;
  localparam int unsigned TAP_D = (DATA_WIDTH == 32) ? 0  : (DATA_WIDTH == 64) ? 59 : 98;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEED  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  function automatic logic tap_parity(input logic [DATA_WIDTH-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

  logic [2:0]              state;
  logic [2:0]              state_next;
  logic [COUNT_WIDTH-1:0]  target;
  logic [PIPE_LATENCY-1:0] pipe;
  logic [STIM_WIDTH-1:0]   lfsr_next;
  logic [DATA_WIDTH-1:0]   misr_next;
  logic                    accept;
  logic                    last_issue;

  assign accept       = start && ((state == S_IDLE) || (state == S_DONE));
  assign stim_valid   = (state == S_RUN) && !stall;
  assign last_issue   = stim_valid && ((tests_issued + COUNT_WIDTH'(1)) == target);
  assign resp_capture = pipe[PIPE_LATENCY-1];
  assign busy         = (state == S_SEED) || (state == S_RUN) || (state == S_DRAIN);
  assign done         = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_next = S_SEED;
      S_SEED:         state_next = (target == '0) ? S_DONE : S_RUN;
      S_RUN:          if (last_issue) state_next = S_DRAIN;
      S_DRAIN:        if (pipe == '0) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // XNOR-feedback step for every channel; the MISR uses XOR feedback on the same taps.
  always_comb begin
    lfsr_next = stim_data;
    for (int c = 0; c < int'(NUM_CHANNELS); c++) begin
      lfsr_next[c*DATA_WIDTH +: DATA_WIDTH] =
        {stim_data[c*DATA_WIDTH +: DATA_WIDTH-1], ~tap_parity(stim_data[c*DATA_WIDTH +: DATA_WIDTH])};
    end
    misr_next = {signature[DATA_WIDTH-2:0], tap_parity(signature)} ^ resp_data;
  end

  // Stalled cycles shift zeros through the latency pipe so captures stay aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim_data    <= '0;
      target       <= '0;
      tests_issued <= '0;
      signature    <= '0;
      pipe         <= '0;
    end else if (accept) begin
      stim_data    <= seeds;
      target       <= num_tests;
      tests_issued <= '0;
      signature    <= '0;
      pipe         <= '0;
    end else begin
      pipe <= PIPE_LATENCY'({pipe, stim_valid});
      if (stim_valid) begin
        stim_data    <= lfsr_next;
        tests_issued <= tests_issued + COUNT_WIDTH'(1);
      end
      if (resp_capture) signature <= misr_next;
    end
  end

endmodule

// File: tb/tb_lfsr_stim_sequencer.sv
// Scoreboard bench for lfsr_stim_sequencer: a 32-bit single-channel instance with latency 2
// and a default-parameter instance fed by a behavioural stand-in for the cipher core.
module tb_lfsr_stim_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_start, a_stall, a_valid, a_cap, a_busy, a_done;
  logic [31:0] a_num, a_seeds, a_stim, a_resp, a_issued, a_sig;

  logic         b_start, b_stall, b_valid, b_cap, b_busy, b_done;
  logic [31:0]  b_num, b_issued;
  logic [255:0] b_seeds, b_stim;
  logic [127:0] b_resp, b_sig;

  lfsr_stim_sequencer #(.DATA_WIDTH(32), .NUM_CHANNELS(1), .PIPE_LATENCY(2), .COUNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .num_tests(a_num), .seeds(a_seeds), .stall(a_stall),
    .stim_data(a_stim), .stim_valid(a_valid), .resp_data(a_resp), .resp_capture(a_cap),
    .busy(a_busy), .done(a_done), .tests_issued(a_issued), .signature(a_sig));

  lfsr_stim_sequencer dut_b (
    .clk(clk), .rst(rst), .start(b_start), .num_tests(b_num), .seeds(b_seeds), .stall(b_stall),
    .stim_data(b_stim), .stim_valid(b_valid), .resp_data(b_resp), .resp_capture(b_cap),
    .busy(b_busy), .done(b_done), .tests_issued(b_issued), .signature(b_sig));

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [127:0] a_exp[$];
  int           a_due[$];
  logic [127:0] a_msig;
  int           a_ncap, a_nv;

  logic [255:0] b_exp[$];
  int           b_due[$];
  logic [127:0] b_rq[$];
  logic [127:0] b_msig;
  int           b_ncap, b_nv;

  function automatic logic [127:0] wmask(input int w);
    if (w >= 128) return {128{1'b1}};
    return (128'd1 << w) - 128'd1;
  endfunction

  function automatic logic par(input logic [127:0] s, input int w);
    int t[4];
    logic p;
    p = 1'b0;
    if (w == 32)      t = '{32, 22, 2, 1};
    else if (w == 64) t = '{64, 63, 61, 60};
    else              t = '{128, 126, 101, 99};
    for (int i = 0; i < 4; i++) p = p ^ s[t[i]-1];
    return p;
  endfunction

  function automatic logic [127:0] lstep(input logic [127:0] s, input int w);
    return ((s << 1) | 128'(!par(s, w))) & wmask(w);
  endfunction

  function automatic logic [127:0] misr(input logic [127:0] s, input logic [127:0] d, input int w);
    return (((s << 1) | 128'(par(s, w))) ^ d) & wmask(w);
  endfunction

  // Stand-in for the cipher core: a fixed mix of both channels.
  function automatic logic [127:0] core(input logic [255:0] v);
    return v[127:0] ^ {v[191:128], v[255:192]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [255:0] e;
    if (a_stall) chk("a_stall_hold", a_valid, 0);
    if (a_valid) begin
      a_nv++;
      if (a_exp.size() == 0) chk("a_extra_valid", 1, 0);
      else begin
        e = a_exp.pop_front();
        chk("a_stim", a_stim, e);
      end
      a_due.push_back(cyc + 2);
    end
    if (a_cap) begin
      if (a_due.size() == 0) chk("a_extra_cap", 1, 0);
      else chk("a_cap_time", cyc, a_due.pop_front());
      a_msig = misr(a_msig, 128'(a_resp), 32);
      a_ncap++;
    end
    if (b_valid) begin
      b_nv++;
      if (b_exp.size() == 0) begin
        chk("b_extra_valid", 1, 0);
        e = b_stim;
      end else begin
        e = b_exp.pop_front();
        chk("b_stim", b_stim, e);
      end
      b_due.push_back(cyc + 21);
      b_rq.push_back(core(e));
    end
    if (b_cap) begin
      if (b_due.size() == 0) chk("b_extra_cap", 1, 0);
      else begin
        chk("b_cap_time", cyc, b_due.pop_front());
        void'(b_rq.pop_front());
      end
      b_msig = misr(b_msig, b_resp, 128);
      b_ncap++;
    end
    chk("busy_done_excl", (a_busy & a_done) | (b_busy & b_done), 0);
  endtask

  // One clock: present the core response, sample outputs, then advance past the edge.
  task automatic cycle();
    if (b_due.size() > 0 && b_due[0] == cyc) b_resp = b_rq[0];
    else b_resp = {$urandom, $urandom, $urandom, $urandom};
    #1;
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_a(input logic [31:0] seed, input logic [31:0] n);
    logic [127:0] s;
    a_msig = '0; a_ncap = 0; a_nv = 0;
    a_exp.delete(); a_due.delete();
    s = 128'(seed);
    for (int k = 0; k < int'(n); k++) begin
      a_exp.push_back(s);
      s = lstep(s, 32);
    end
    a_seeds = seed; a_num = n; a_start = 1'b1;
    cycle();
    a_start = 1'b0;
  endtask

  task automatic finish_a(input logic [31:0] n, input int stall_after, input int stall_len, input bit const_resp);
    int st;
    st = 0;
    for (int k = 0; k < 200 && !a_done; k++) begin
      a_stall = (a_nv >= stall_after) && (st < stall_len) && a_busy;
      if (a_stall) st++;
      a_resp = const_resp ? 32'h1 : $urandom;
      cycle();
    end
    a_stall = 1'b0;
    chk("a_done", a_done, 1);
    chk("a_busy_at_done", a_busy, 0);
    chk("a_tests_issued", a_issued, n);
    chk("a_captures", a_ncap, n);
    chk("a_exp_left", a_exp.size(), 0);
    chk("a_due_left", a_due.size(), 0);
    chk("a_signature", a_sig, a_msig);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] s0, s1;
    bit pulsed;
    rst = 1'b1;
    a_start = 0; a_stall = 0; a_num = 0; a_seeds = 0; a_resp = 0;
    b_start = 0; b_stall = 0; b_num = 0; b_seeds = 0; b_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_stim", a_stim, 0);
    chk("rst_a_flags", {a_valid, a_cap, a_busy, a_done}, 0);
    chk("rst_a_issued", a_issued, 0);
    chk("rst_a_sig", a_sig, 0);
    chk("rst_b_stim", b_stim, 0);
    chk("rst_b_flags", {b_valid, b_cap, b_busy, b_done}, 0);
    rst = 1'b0;
    cycle();

    // Basic run: known sequence from seed 1.
    start_a(32'h1, 4);
    a_exp = '{128'h1, 128'h2, 128'h4, 128'h9};
    finish_a(4, 1000, 0, 1'b1);

    // Single and double response folding with constant response 1.
    start_a(32'h1, 1);
    finish_a(1, 1000, 0, 1'b1);
    chk("a_sig_n1", a_sig, 32'h1);
    start_a(32'h1, 2);
    finish_a(2, 1000, 0, 1'b1);
    chk("a_sig_n2", a_sig, 32'h2);

    // Stall for 3 cycles after the second issue.
    start_a(32'h1, 4);
    finish_a(4, 2, 3, 1'b0);

    // Zero tests: straight through SEED to DONE.
    start_a(32'h1, 0);
    chk("a_seed_busy", a_busy, 1);
    finish_a(0, 1000, 0, 1'b0);
    chk("a_sig_n0", a_sig, 0);

    // Reset mid-run, then restart from a new seed.
    start_a(32'h1234_5678, 20);
    repeat (6) begin
      a_resp = $urandom;
      cycle();
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_stim", a_stim, 0);
    chk("midrst_flags", {a_valid, a_cap, a_busy, a_done}, 0);
    chk("midrst_issued", a_issued, 0);
    chk("midrst_sig", a_sig, 0);
    start_a(32'hACE1_0001, 5);
    finish_a(5, 1000, 0, 1'b0);

    // Default parameters with two channels and a stray start during RUN.
    s0 = {4{32'hDEADBEEF}};
    s1 = {4{32'hCAFEFEED}};
    b_msig = '0; b_ncap = 0; b_nv = 0;
    for (int k = 0; k < 10; k++) begin
      b_exp.push_back({s1, s0});
      s0 = lstep(s0, 128);
      s1 = lstep(s1, 128);
    end
    b_seeds = {{4{32'hCAFEFEED}}, {4{32'hDEADBEEF}}};
    b_num = 10; b_start = 1'b1;
    cycle();
    b_start = 1'b0;
    pulsed = 1'b0;
    for (int k = 0; k < 400 && !b_done; k++) begin
      if (b_nv == 3 && !pulsed) begin
        b_start = 1'b1; b_num = 3; b_seeds = '0; pulsed = 1'b1;
      end
      cycle();
      b_start = 1'b0;
    end
    chk("b_done", b_done, 1);
    chk("b_tests_issued", b_issued, 10);
    chk("b_captures", b_ncap, 10);
    chk("b_exp_left", b_exp.size(), 0);
    chk("b_due_left", b_due.size(), 0);
    chk("b_signature", b_sig, b_msig);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_stim_sequencer.md
Name: lfsr_stim_sequencer

Overview:
Synthesizable, parametrised successor to the fixed two-LFSR AES stimulus arrangement. It drives NUM_CHANNELS independent LFSR channels (e.g. plaintext and key) into a pipelined cipher core for a programmable number of tests. It tracks the core's fixed pipeline latency, compresses every response into a MISR signature and reports completion. It sits between the bench or BIST controller and the cipher core, replacing free-running LFSRs and hand-timed delays.

Parameters:
DATA_WIDTH, 128, width of each channel and of the response; legal values 32, 64, 128 only.
NUM_CHANNELS, 2, number of independent LFSR stimulus channels (1..4).
PIPE_LATENCY, 21, cycles from a stimulus issue to its response being valid (>=1).
COUNT_WIDTH, 32, width of the test counters.

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts a run; sampled only in IDLE or DONE
num_tests  in  COUNT_WIDTH  number of stimuli to issue; sampled with start
seeds  in  NUM_CHANNELS*DATA_WIDTH  per-channel seeds; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH]; sampled with start
stall  in  1  when high in RUN, freezes issue
stim_data  out  NUM_CHANNELS*DATA_WIDTH  current LFSR states, same packing as seeds
stim_valid  out  1  stim_data is a new test vector this cycle
resp_data  in  DATA_WIDTH  core output
resp_capture  out  1  resp_data is being folded into the signature this cycle
busy  out  1  high in SEED, RUN, DRAIN
done  out  1  high in DONE
tests_issued  out  COUNT_WIDTH  number of stim_valid cycles in the current run
signature  out  DATA_WIDTH  MISR value

Behaviour:
- Reset: all outputs 0; FSM goes to IDLE; all LFSRs, MISR, counters and latency pipe are cleared. Reset mid-run aborts immediately, with no partial done.
- FSM states: IDLE, SEED, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch num_tests, load every LFSR from seeds, clear signature, tests_issued and latency pipe, then go to SEED.
- SEED (1 cycle): if the latched num_tests==0, go to DONE; otherwise go to RUN.
- RUN: when stall=0, stim_valid=1, stim_data equals the current LFSR states, all LFSRs advance at the clock edge and tests_issued increments. When stall=1, stim_valid=0 and LFSRs and counter hold. When the Nth issue occurs, go to DRAIN on the next edge.
- The first issued vector equals the seed itself.
- DRAIN: stay until the latency pipe is empty, then go to DONE.
- DONE: done=1; signature and tests_issued hold. start restarts the run; start in any other state is ignored.
- LFSR step: next = {s[W-2:0], fb}, where fb = XNOR of the tap bits. Taps (1-based):
  - 32: 32,22,2,1
  - 64: 64,63,61,60
  - 128: 128,126,101,99
- An all-ones seed is a lock-up state; the block does not check for it.
- Latency pipe: a PIPE_LATENCY-deep shift register of stim_valid. resp_capture equals stim_valid delayed by exactly PIPE_LATENCY cycles. Stalled cycles shift 0s through, so responses stay aligned with their stimuli.
- MISR: on resp_capture, sig <= {sig[W-2:0], p} ^ resp_data, where p = XOR of the same tap bits of sig. Otherwise sig holds.
- The number of resp_capture pulses per run always equals num_tests.
- Counters wrap modulo 2^COUNT_WIDTH. num_tests = 2^COUNT_WIDTH-1 is legal.
- busy and done are never high together.

Test Plan:
- DATA_WIDTH=32, NUM_CHANNELS=1, seed 0x00000001, num_tests=4, no stall -> stim_data 0x1, 0x2, 0x4, 0x9 on four consecutive stim_valid cycles; tests_issued=4; done after DRAIN.
- PIPE_LATENCY=2, num_tests=1, resp_data held at 0x1 -> resp_capture exactly 2 cycles after stim_valid; signature=0x00000001. With num_tests=2 -> signature=0x00000002.
- Stall held high for 3 cycles after the second issue -> stim_valid low for 3 cycles; third vector still 0x4; resp_capture pattern equals the stim_valid pattern shifted by PIPE_LATENCY; total of 4 captures.
- num_tests=0 -> SEED then DONE; no stim_valid, no resp_capture; signature=0; tests_issued=0.
- rst asserted mid-RUN, then a new start with a different seed -> all outputs 0 in the cycle after reset; the new run begins from the new seed with no carry-over of the signature.
- Default parameters (128-bit, 2 channels, latency 21) with seeds 0xDEADBEEF... and 0xCAFEFEED..., num_tests=10, connected to the cipher core -> 10 captures; signature matches a reference-model MISR over the golden ciphertexts; a start pulse during RUN is ignored.
